// File: rtl/simple_pkg.sv
// Shared types and the half-word transform for the simple_pipe_n pipeline.
package simple_pkg;

  typedef enum logic {
    OP_COMBINE = 1'b0,
    OP_BYPASS  = 1'b1
  } op_e;

  // Widest data path the generic combine helper can serve.
  localparam int unsigned MAX_W = 64;

  // Upper half becomes hi^lo, lower half hi&lo; w is the live data width (even).
  function automatic logic [MAX_W-1:0] combine(input logic [MAX_W-1:0] data,
                                               input int unsigned      w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] hi;
    logic [MAX_W-1:0] lo;
    mask = (MAX_W'(1) << (w / 2)) - MAX_W'(1);
    hi   = (data >> (w / 2)) & mask;
    lo   = data & mask;
    return ((hi ^ lo) << (w / 2)) | (hi & lo);
  endfunction

endpackage

// File: rtl/simple_pipe_n_if.sv
// Valid/ready bus bundle for simple_pipe_n: input beat, output beat and occupancy.
interface simple_pipe_n_if #(
  parameter int unsigned W      = 2,
  parameter int unsigned STAGES = 1
);
  import simple_pkg::*;

  localparam int unsigned CW = $clog2(STAGES + 1);

  logic [W-1:0]  in_data;
  op_e           in_op;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] occupancy;

  modport master (
    output in_data, in_op, in_valid, out_ready,
    input  in_ready, out_data, out_valid, occupancy
  );

  modport slave (
    input  in_data, in_op, in_valid, out_ready,
    output in_ready, out_data, out_valid, occupancy
  );

endinterface

// File: rtl/simple_slice.sv
// One elastic register slice: loads whenever it is empty or its beat is leaving.
module simple_slice #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] up_data,
  input  logic         up_valid,
  input  logic         dn_ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         ready_c
);

  // Local ready: room now, or the held beat moves on this cycle.
  assign ready_c = dn_ready || !valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (up_valid && ready_c) begin
      data  <= up_data;
      valid <= 1'b1;
    end else if (valid && ready_c) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/simple_pipe_n.sv
// Elastic STAGES-deep valid/ready pipeline applying a per-beat half-word transform.
module simple_pipe_n
  import simple_pkg::*;
#(
  parameter int unsigned W      = 2,
  parameter int unsigned STAGES = 1
) (
  input  logic          clk,
  input  logic          rst,
  simple_pipe_n_if.slave bus
);

  localparam int unsigned CW = $clog2(STAGES + 1);

  if ((W < 2) || ((W % 2) != 0) || (W > MAX_W)) begin : g_bad_w
    $error("simple_pipe_n: W must be even, >= 2 and <= MAX_W");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("simple_pipe_n: STAGES must be >= 1");
  end

  logic [W-1:0] xform_c;
  logic         accept_c;
  logic         emit_c;
  logic [CW-1:0] occ;

  // Transform ahead of slice 0; in_op only matters on the accepted beat.
  always_comb begin
    xform_c = W'(combine(MAX_W'(bus.in_data), W));
    if (bus.in_op == OP_BYPASS) begin
      xform_c = bus.in_data;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    logic [W-1:0] up_data;
    logic         up_valid;
    logic         dn_ready;
    logic [W-1:0] d_q;
    logic         v_q;
    logic         rdy_c;

    if (i == 0) begin : g_head
      assign up_data  = xform_c;
      assign up_valid = bus.in_valid;
    end else begin : g_body
      assign up_data  = g_slice[i-1].d_q;
      assign up_valid = g_slice[i-1].v_q;
    end

    if (i == STAGES - 1) begin : g_tail
      assign dn_ready = bus.out_ready;
    end else begin : g_mid
      assign dn_ready = g_slice[i+1].rdy_c;
    end

    simple_slice #(.W(W)) u_slice (
      .clk      (clk),
      .rst      (rst),
      .up_data  (up_data),
      .up_valid (up_valid),
      .dn_ready (dn_ready),
      .data     (d_q),
      .valid    (v_q),
      .ready_c  (rdy_c)
    );
  end

  assign bus.in_ready  = g_slice[0].rdy_c;
  assign bus.out_data  = g_slice[STAGES-1].d_q;
  assign bus.out_valid = g_slice[STAGES-1].v_q;

  assign accept_c = bus.in_valid && bus.in_ready;
  assign emit_c   = bus.out_valid && bus.out_ready;

  // Occupancy tracks the popcount of slice valids; accept+emit together nets to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else if (accept_c && !emit_c) begin
      occ <= occ + CW'(1);
    end else if (!accept_c && emit_c) begin
      occ <= occ - CW'(1);
    end
  end

  assign bus.occupancy = occ;

endmodule

// File: tb/tb_simple_pipe_n.sv
// Self-checking bench for simple_pipe_n: W=4/STAGES=3 directed and W=2/STAGES=1 random.
module tb_simple_pipe_n;
  import simple_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  simple_pipe_n_if #(.W(4), .STAGES(3)) bus_a ();
  simple_pipe_n_if #(.W(2), .STAGES(1)) bus_b ();

  simple_pipe_n #(.W(4), .STAGES(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  simple_pipe_n #(.W(2), .STAGES(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Reference transform from the half-word rules.
  function automatic logic [3:0] ref4(input logic [3:0] d, input bit op);
    logic [1:0] hi;
    logic [1:0] lo;
    hi = d[3:2];
    lo = d[1:0];
    return op ? d : {hi ^ lo, hi & lo};
  endfunction

  function automatic logic [1:0] ref2(input logic [1:0] d, input bit op);
    logic hi;
    logic lo;
    hi = d[1];
    lo = d[0];
    return op ? d : {hi ^ lo, hi & lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("FAIL reset_a_out_valid got=%0b exp=0", bus_a.out_valid); end
    checks++; if (bus_a.out_data !== 4'h0) begin failures++; $display("FAIL reset_a_out_data got=%0h exp=0", bus_a.out_data); end
    checks++; if (bus_a.occupancy !== 2'd0) begin failures++; $display("FAIL reset_a_occupancy got=%0d exp=0", bus_a.occupancy); end
    checks++; if (bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL reset_a_in_ready got=%0b exp=1", bus_a.in_ready); end
    checks++; if (bus_b.out_valid !== 1'b0) begin failures++; $display("FAIL reset_b_out_valid got=%0b exp=0", bus_b.out_valid); end
    checks++; if (bus_b.in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_in_ready got=%0b exp=1", bus_b.in_ready); end
    tick();
  endtask

  // One beat with out_ready held high: check latency, data and occupancy profile.
  task automatic test_latency(input logic [3:0] din, input bit op, input logic [3:0] exp, input string name);
    bus_a.out_ready = 1'b1;
    bus_a.in_data   = din;
    bus_a.in_op     = op_e'(op);
    bus_a.in_valid  = 1'b1;
    @(negedge clk);
    checks++; if (bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL %s_accept got=%0b exp=1", name, bus_a.in_ready); end
    tick();
    bus_a.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (bus_a.out_valid !== (k == 3)) begin failures++; $display("FAIL %s_out_valid cycle=%0d got=%0b exp=%0b", name, k, bus_a.out_valid, (k == 3)); end
      checks++; if (32'(bus_a.occupancy) !== ((k <= 3) ? 1 : 0)) begin failures++; $display("FAIL %s_occupancy cycle=%0d got=%0d exp=%0d", name, k, bus_a.occupancy, (k <= 3) ? 1 : 0); end
      if (k == 3) begin
        checks++; if (bus_a.out_data !== exp) begin failures++; $display("FAIL %s_out_data got=%04b exp=%04b", name, bus_a.out_data, exp); end
      end
      tick();
    end
  endtask

  task automatic test_combine();
    test_latency(4'b1011, 1'b0, 4'b0110, "combine");
  endtask

  task automatic test_bypass();
    test_latency(4'b1011, 1'b1, 4'b1011, "bypass");
  endtask

  // Stall downstream, fill via bubble collapsing, then drain in order.
  task automatic test_backpressure();
    int idx = 1;
    int got = 0;
    bus_a.out_ready = 1'b0;
    bus_a.in_op     = OP_BYPASS;
    for (int c = 0; c < 5; c++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 4'(idx);
      @(negedge clk);
      checks++; if (bus_a.in_ready !== (c < 3)) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%0b exp=%0b", c, bus_a.in_ready, (c < 3)); end
      if (c >= 3) begin
        checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 4'd1) begin failures++; $display("FAIL bp_stall_hold cycle=%0d got=%0b/%0d exp=1/1", c, bus_a.out_valid, bus_a.out_data); end
        checks++; if (bus_a.occupancy !== 2'd3) begin failures++; $display("FAIL bp_occupancy cycle=%0d got=%0d exp=3", c, bus_a.occupancy); end
      end
      if (bus_a.in_ready) idx++;
      tick();
    end
    bus_a.out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      bus_a.in_valid = (idx <= 5);
      bus_a.in_data  = 4'(idx);
      @(negedge clk);
      if (bus_a.out_valid) begin
        checks++; if (bus_a.out_data !== 4'(got + 1)) begin failures++; $display("FAIL bp_order n=%0d got=%0d exp=%0d", got, bus_a.out_data, got + 1); end
        got++;
      end
      if (bus_a.in_valid && bus_a.in_ready) idx++;
      tick();
    end
    bus_a.in_valid = 1'b0;
    checks++; if (got !== 5 || idx !== 6) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=5/6", got, idx - 1); end
    @(negedge clk);
    checks++; if (bus_a.out_valid !== 1'b0 || bus_a.occupancy !== 2'd0) begin failures++; $display("FAIL bp_drained got=%0b/%0d exp=0/0", bus_a.out_valid, bus_a.occupancy); end
    tick();
  endtask

  // Full pipe with accept and emit every cycle for 10 cycles.
  task automatic test_back_to_back();
    logic [3:0] q[$];
    logic [3:0] d;
    bit         op;
    bus_a.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      d = 4'($urandom); op = 1'($urandom);
      bus_a.in_valid = 1'b1; bus_a.in_data = d; bus_a.in_op = op_e'(op);
      @(negedge clk);
      checks++; if (bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_fill_ready cycle=%0d got=%0b exp=1", c, bus_a.in_ready); end
      if (bus_a.in_ready) q.push_back(ref4(d, op));
      tick();
    end
    bus_a.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      d = 4'($urandom); op = 1'($urandom);
      bus_a.in_data = d; bus_a.in_op = op_e'(op);
      @(negedge clk);
      checks++; if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_handshake cycle=%0d got=%0b/%0b exp=1/1", c, bus_a.in_ready, bus_a.out_valid); end
      checks++; if (bus_a.occupancy !== 2'd3) begin failures++; $display("FAIL b2b_occupancy cycle=%0d got=%0d exp=3", c, bus_a.occupancy); end
      if (bus_a.out_valid && q.size() > 0) begin
        checks++; if (bus_a.out_data !== q[0]) begin failures++; $display("FAIL b2b_data cycle=%0d got=%0h exp=%0h", c, bus_a.out_data, q[0]); end
        void'(q.pop_front());
      end
      if (bus_a.in_ready) q.push_back(ref4(d, op));
      tick();
    end
    bus_a.in_valid = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(negedge clk);
      if (bus_a.out_valid) begin
        checks++; if (bus_a.out_data !== q[0]) begin failures++; $display("FAIL b2b_drain got=%0h exp=%0h", bus_a.out_data, q[0]); end
        void'(q.pop_front());
      end
      tick();
    end
    checks++; if (q.size() !== 0) begin failures++; $display("FAIL b2b_drain_timeout left=%0d exp=0", q.size()); end
  endtask

  // Reset with two beats buffered and a live input handshake.
  task automatic test_reset_mid();
    bus_a.out_ready = 1'b0;
    bus_a.in_op     = OP_BYPASS;
    for (int c = 0; c < 2; c++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 4'(4'hA + c);
      tick();
    end
    rst = 1'b1;
    bus_a.in_data = 4'hC;
    @(negedge clk);
    checks++; if (bus_a.occupancy !== 2'd2 || bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%0d/%0b exp=2/1", bus_a.occupancy, bus_a.in_ready); end
    tick();
    rst = 1'b0;
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 4'h0) begin failures++; $display("FAIL rstmid_out got=%0b/%0h exp=0/0", bus_a.out_valid, bus_a.out_data); end
    checks++; if (bus_a.occupancy !== 2'd0 || bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_state got=%0d/%0b exp=0/1", bus_a.occupancy, bus_a.in_ready); end
    tick();
    bus_a.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ghost cycle=%0d got=%0b exp=0", c, bus_a.out_valid); end
      tick();
    end
  endtask

  // W=2, STAGES=1: directed combine of 2'b11, then random valid/ready traffic.
  task automatic test_random_w2();
    logic [1:0] q[$];
    logic [1:0] d;
    logic [1:0] prev_data = '0;
    bit         op;
    bit         prev_stall = 1'b0;
    bus_b.out_ready = 1'b1;
    bus_b.in_data   = 2'b11;
    bus_b.in_op     = OP_COMBINE;
    bus_b.in_valid  = 1'b1;
    @(negedge clk);
    checks++; if (bus_b.in_ready !== 1'b1) begin failures++; $display("FAIL w2_combine_accept got=%0b exp=1", bus_b.in_ready); end
    tick();
    bus_b.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== 2'b01) begin failures++; $display("FAIL w2_combine11 got=%0b/%02b exp=1/01", bus_b.out_valid, bus_b.out_data); end
    tick();
    for (int c = 0; c < 1000; c++) begin
      d = 2'($urandom); op = 1'($urandom);
      bus_b.in_valid  = 1'($urandom_range(0, 1));
      bus_b.in_data   = d;
      bus_b.in_op     = op_e'(op);
      bus_b.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (32'(bus_b.occupancy) !== q.size()) begin failures++; $display("FAIL w2_occupancy cycle=%0d got=%0d exp=%0d", c, bus_b.occupancy, q.size()); end
      checks++; if (bus_b.in_ready !== (bus_b.out_ready || q.size() < 1)) begin failures++; $display("FAIL w2_in_ready cycle=%0d got=%0b exp=%0b", c, bus_b.in_ready, (bus_b.out_ready || q.size() < 1)); end
      if (prev_stall) begin
        checks++; if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== prev_data) begin failures++; $display("FAIL w2_stall_stable cycle=%0d got=%0b/%0h exp=1/%0h", c, bus_b.out_valid, bus_b.out_data, prev_data); end
      end
      if (bus_b.out_valid) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL w2_spurious cycle=%0d got=%0h exp=none", c, bus_b.out_data); end
        else if (bus_b.out_data !== q[0]) begin failures++; $display("FAIL w2_data cycle=%0d got=%0h exp=%0h", c, bus_b.out_data, q[0]); end
        if (bus_b.out_ready && q.size() > 0) void'(q.pop_front());
      end
      if (bus_b.in_valid && bus_b.in_ready) q.push_back(ref2(d, op));
      prev_stall = bus_b.out_valid && !bus_b.out_ready;
      prev_data  = bus_b.out_data;
      tick();
    end
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      @(negedge clk);
      if (bus_b.out_valid) begin
        checks++; if (bus_b.out_data !== q[0]) begin failures++; $display("FAIL w2_drain got=%0h exp=%0h", bus_b.out_data, q[0]); end
        void'(q.pop_front());
      end
      tick();
    end
    checks++; if (q.size() !== 0) begin failures++; $display("FAIL w2_drain_timeout left=%0d exp=0", q.size()); end
  endtask

  initial begin
    bus_a.in_data = '0; bus_a.in_op = OP_COMBINE; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_data = '0; bus_b.in_op = OP_COMBINE; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
    test_reset();
    test_combine();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random_w2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/simple_pipe_n.md
Name: simple_pipe_n

Overview:
Parametrised elastic valid/ready pipeline that applies a half-word transform to each input beat and carries the result through STAGES register slices. It is the multi-stage, multi-mode generalisation of the single-slice split-and-combine block, and serves as a small sequential test design for the masking/verification flow. It adds a per-beat operation select, configurable depth, and an occupancy output. Full throughput with bubble collapsing.

Parameters:
W, 2, data width; must be even and >= 2 (elaboration error otherwise)
STAGES, 1, number of register slices; must be >= 1
CW, $clog2(STAGES+1), occupancy counter width (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_data  input  W  input beat; hi = in_data[W-1:W/2], lo = in_data[W/2-1:0]
in_op  input  1  per-beat operation select (0 = COMBINE, 1 = BYPASS)
in_valid  input  1  input beat valid
in_ready  output  1  block accepts beat this cycle
out_data  output  W  result of the last slice
out_valid  output  1  last slice holds a valid beat
out_ready  input  1  downstream accepts
occupancy  output  CW  number of valid slices

Behaviour:
- Clock clk; reset rst, synchronous, active-high. rst has priority over every other update in the same cycle.
- Transform, applied combinationally before slice 0:
  - COMBINE: result[W-1:W/2] = hi ^ lo; result[W/2-1:0] = hi & lo.
  - BYPASS: result = in_data.
- Slice i holds data d[i] and valid v[i]. Slice 0 takes the transform result; slice i>0 takes d[i-1].
- Ready chain: rdy[STAGES-1] = out_ready || !v[STAGES-1]; rdy[i] = rdy[i+1] || !v[i]. in_ready = rdy[0]. The chain is purely combinational and contains no path from in_valid.
- Slice i loads when upstream is valid and rdy[i] is high:
  - d[i] <= upstream data; v[i] <= 1.
  - Otherwise, if v[i] && rdy[i], v[i] <= 0 (the beat has moved on).
  - Otherwise the slice holds.
- out_data = d[STAGES-1]; out_valid = v[STAGES-1].
- Data must not change while out_valid && !out_ready.
- Latency: a beat accepted in cycle t appears at out_valid in cycle t+STAGES when there is no backpressure. Throughput is one beat per cycle sustained.
- Bubble collapsing: an empty slice accepts even when downstream is stalled, so up to STAGES beats are buffered before in_ready drops.
- Full: all v = 1 and out_ready = 0 gives in_ready = 0. With all v = 1 and out_ready = 1, in_ready = 1, and simultaneous accept and emit is legal: occupancy is unchanged.
- Empty: out_valid = 0; out_ready is ignored.
- occupancy is registered and equals the popcount of v. Its update is +1 on accept-only, -1 on emit-only, and unchanged on both or neither. It never exceeds STAGES and never underflows.
- Reset values: all v = 0, all d = 0, occupancy = 0. Therefore out_valid = 0 and out_data = 0, and in_ready = 1 combinationally once reset is released.
- Reset mid-operation: all buffered beats are discarded with no output; an input handshake in the reset cycle is dropped.
- in_op is sampled only on an accepted beat and has no effect otherwise.

Decomposition:
- Package simple_pkg:
  - op_e enum (OP_COMBINE = 1'b0, OP_BYPASS = 1'b1).
  - combine function (W-generic, used by RTL and the scoreboard model).
- Sub-module simple_slice: one elastic register slice (data, valid, up/down handshake, local ready). It is instantiated STAGES times by a generate loop; the top holds the transform and the occupancy counter.

Test Plan:
- W=4, STAGES=3, after reset, hold out_ready=1; send 4'b1011 with op=0 -> out_data=4'b0110 with out_valid exactly 3 cycles after accept; occupancy goes 1, then 0.
- Same configuration, 4'b1011 with op=1 -> out_data=4'b1011 after 3 cycles.
- out_ready=0, in_valid=1 for 5 cycles with beats 1,2,3,4,5 (op=1):
  - in_ready drops after 3 accepts; occupancy=3; out_data stable at 1.
  - Then out_ready=1 -> beats 1,2,3,4,5 emerge in order with no loss or duplication.
- Full pipe, in_valid=1 and out_ready=1 together for 10 cycles with random data -> one accept and one emit per cycle, occupancy constant at 3, outputs match the package-function model.
- Assert rst for one cycle with occupancy=2 and an in_valid handshake present -> next cycle: out_valid=0, out_data=0, occupancy=0, in_ready=1; the dropped beats never appear.
- W=2, STAGES=1, random valid/ready toggling for 1000 cycles:
  - Scoreboard against the model: output order matches, and COMBINE of 2'b11 yields 2'b01.
  - Stall-stability assertion holds throughout.
